// File: rtl/axis_trace_tx.sv
// rtl/axis_trace_tx.sv - timestamped trace event packer driving an AXIS master port
//
// Purpose: stamps each captured event with a free-running timestamp and emits
// it as one {id, timestamp} beat. Beats are grouped into C_PKT_LEN-beat packets
// delimited by tlast. A packet left idle for C_FLUSH_TIMEOUT cycles is closed by
// a marker beat {all-ones, timestamp}. Events that find the output beat occupied
// are dropped and counted.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   enable               event capture enable (disabled strobes are not drops)
//   event_valid/event_id one-cycle event strobe and its identifier
//   out_tdata/out_tvalid/out_tready/out_tlast  AXIS master (FIFO write side)
//   dropped_count        saturating count of dropped events
module axis_trace_tx #(
   parameter int C_DATA_WIDTH    = 32,
   parameter int C_ID_WIDTH      = 8,
   parameter int C_PKT_LEN       = 4,
   parameter int C_FLUSH_TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    event_valid,
   input  logic [C_ID_WIDTH-1:0]   event_id,
   output logic [C_DATA_WIDTH-1:0] out_tdata,
   output logic                    out_tvalid,
   input  logic                    out_tready,
   output logic                    out_tlast,
   output logic [15:0]             dropped_count
);

   localparam int TS_W = C_DATA_WIDTH - C_ID_WIDTH;
   localparam int BC_W = $clog2(C_PKT_LEN);
   localparam int TC_W = $clog2(C_FLUSH_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_PKT, S_FLUSH} state_t;

   state_t                  state_q;
   logic [TS_W-1:0]         ts_q;
   logic [TS_W-1:0]         ts_d;
   logic [BC_W-1:0]         bcnt_q;
   logic [TC_W-1:0]         tcnt_q;
   logic [15:0]             drop_q;
   logic [15:0]             drop_d;
   logic [C_DATA_WIDTH-1:0] tdata_q;
   logic                    tvalid_q;
   logic                    tlast_q;

   logic ev;
   logic slot_free;
   logic expire;
   logic flush_due;
   logic pkt_end;

   assign ev        = enable && event_valid;
   // The beat register may be overwritten when empty or when its beat is
   // handed off in this same cycle.
   assign slot_free = !tvalid_q || out_tready;
   // Expiry is the idle cycle in which tcnt would reach the timeout, so the
   // marker can be loaded in that cycle and appear one cycle later.
   assign expire    = (state_q == S_PKT) && !ev &&
                      (tcnt_q == TC_W'(C_FLUSH_TIMEOUT - 1));
   assign flush_due = (state_q == S_FLUSH) || expire;
   // An event accepted while a flush is pending closes the packet itself.
   assign pkt_end   = (bcnt_q == BC_W'(C_PKT_LEN - 1)) || (state_q == S_FLUSH);
   assign ts_d      = ts_q + 1'b1;
   assign drop_d    = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         ts_q     <= '0;
         bcnt_q   <= '0;
         tcnt_q   <= '0;
         drop_q   <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else begin
         ts_q <= ts_d;
         // Handshake empties the register unless a load below refills it.
         if (tvalid_q && out_tready) begin
            tvalid_q <= 1'b0;
         end
         if (ev) begin
            tcnt_q <= '0;
            if (slot_free) begin
               tvalid_q <= 1'b1;
               tdata_q  <= {event_id, ts_q};
               if (pkt_end) begin
                  tlast_q <= 1'b1;
                  bcnt_q  <= '0;
                  state_q <= S_IDLE;
               end else begin
                  tlast_q <= 1'b0;
                  bcnt_q  <= bcnt_q + 1'b1;
                  state_q <= S_PKT;
               end
            end else begin
               drop_q <= drop_d;
            end
         end else if (flush_due) begin
            if (slot_free) begin
               tvalid_q <= 1'b1;
               tdata_q  <= {{C_ID_WIDTH{1'b1}}, ts_q};
               tlast_q  <= 1'b1;
               bcnt_q   <= '0;
               tcnt_q   <= '0;
               state_q  <= S_IDLE;
            end else begin
               state_q  <= S_FLUSH;
            end
         end else if (state_q == S_PKT) begin
            tcnt_q <= tcnt_q + 1'b1;
         end
      end
   end

   assign out_tdata     = tdata_q;
   assign out_tvalid    = tvalid_q;
   assign out_tlast     = tlast_q;
   assign dropped_count = drop_q;

endmodule

// File: tb/tb_axis_trace_tx.sv
// tb/tb_axis_trace_tx.sv - directed scoreboard bench for axis_trace_tx
module tb_axis_trace_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        event_valid;
   logic [7:0]  event_id;
   logic [31:0] out_tdata;
   logic        out_tvalid;
   logic        out_tready;
   logic        out_tlast;
   logic [15:0] dropped_count;

   int checks   = 0;
   int failures = 0;

   logic [23:0] tb_ts;
   logic [32:0] exp_q[$];
   logic [23:0] t_a;
   logic [31:0] held;

   axis_trace_tx dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .event_valid   (event_valid),
      .event_id      (event_id),
      .out_tdata     (out_tdata),
      .out_tvalid    (out_tvalid),
      .out_tready    (out_tready),
      .out_tlast     (out_tlast),
      .dropped_count (dropped_count)
   );

   always #5 clk = ~clk;

   // Reference timestamp: 0 in the first cycle after reset, +1 per cycle.
   always @(posedge clk) begin
      if (reset) tb_ts <= '0;
      else       tb_ts <= tb_ts + 24'd1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Beats are consumed at the next rising edge when valid and ready.
   always @(negedge clk) begin
      if (!reset && out_tvalid && out_tready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", {31'd0, out_tlast, out_tdata}, 64'hDEAD);
         end else begin
            check("beat", {31'd0, out_tlast, out_tdata}, {31'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] id, input bit push, input bit last);
      event_valid = 1'b1;
      event_id    = id;
      if (push) exp_q.push_back({last, id, tb_ts});
      step();
      event_valid = 1'b0;
   endtask

   task automatic push_marker(input logic [23:0] ts);
      exp_q.push_back({1'b1, 8'hFF, ts});
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
      check(tag, exp_q.size(), 0);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; event_valid = 1'b0; event_id = '0; out_tready = 1'b1;
      repeat (3) step();
      check("rst_tvalid", out_tvalid, 0);
      check("rst_tlast", out_tlast, 0);
      check("rst_tdata", out_tdata, 0);
      check("rst_dropped", dropped_count, 0);
      reset = 1'b0;

      // back-to-back packet starting at ts=10
      for (int i = 0; i < 50 && tb_ts != 24'd10; i++) step();
      send(8'd1, 1, 0); send(8'd2, 1, 0); send(8'd3, 1, 0); send(8'd4, 1, 1);
      drain("b2b_drain");
      check("b2b_dropped", dropped_count, 0);
      step();
      check("b2b_tvalid_low", out_tvalid, 0);

      // backpressure: first event held, next two dropped
      out_tready = 1'b0;
      t_a = tb_ts;
      send(8'd5, 1, 0);
      send(8'd6, 0, 0);
      held = {8'd5, t_a};
      t_a = tb_ts;
      send(8'd7, 0, 0);
      check("bp_dropped", dropped_count, 2);
      check("bp_tvalid", out_tvalid, 1);
      check("bp_tdata", out_tdata, held);
      repeat (3) step();
      check("bp_tdata_stable", out_tdata, held);
      check("bp_tlast_stable", out_tlast, 0);
      // the open packet times out relative to the last (dropped) event
      push_marker(t_a + 24'd64);
      out_tready = 1'b1;
      step();
      check("bp_single_beat", out_tvalid, 0);
      drain("bp_marker_drain");

      // timeout flush, then a fresh full packet
      send(8'd8, 1, 0);
      t_a = tb_ts;
      send(8'd9, 1, 0);
      push_marker(t_a + 24'd64);
      drain("flush_drain");
      send(8'd10, 1, 0); send(8'd11, 1, 0); send(8'd12, 1, 0); send(8'd13, 1, 1);
      drain("after_flush_drain");

      // event exactly on the expiry cycle wins over the flush
      send(8'd20, 1, 0); send(8'd21, 1, 0);
      repeat (63) step();
      send(8'd22, 1, 0);
      send(8'd23, 1, 1);
      repeat (80) step();
      check("collision_no_marker", exp_q.size(), 0);

      // disabled capture
      enable = 1'b0;
      send(8'h40, 0, 0); send(8'h40, 0, 0); send(8'h40, 0, 0);
      repeat (3) step();
      check("dis_tvalid", out_tvalid, 0);
      check("dis_dropped", dropped_count, 2);
      enable = 1'b1;
      t_a = tb_ts;
      send(8'h41, 1, 0);
      push_marker(t_a + 24'd64);
      drain("dis_resume_drain");

      // reset with beat 2 of a packet still on the bus
      send(8'd30, 1, 0);
      send(8'd31, 1, 0);
      reset = 1'b1;
      step();
      check("mid_rst_tvalid", out_tvalid, 0);
      check("mid_rst_tlast", out_tlast, 0);
      check("mid_rst_tdata", out_tdata, 0);
      check("mid_rst_dropped", dropped_count, 0);
      exp_q.delete();
      reset = 1'b0;

      // saturation of the drop counter
      out_tready  = 1'b0;
      event_id    = 8'h55;
      event_valid = 1'b1;
      t_a = tb_ts;
      repeat (70000) step();
      event_valid = 1'b0;
      check("sat_dropped", dropped_count, 16'hFFFF);
      check("sat_held_tdata", out_tdata, {8'h55, t_a});
      check("sat_held_tlast", out_tlast, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axis_trace_tx.md
# axis_trace_tx

Single-clock AXI4-Stream trace transmitter for the SDSoC trace framework. It timestamps discrete trace events and packs them into fixed-length, tlast-delimited packets on an AXIS master port. The port drives the write side of the trace AXIS FIFO. Partial packets are closed by a timeout-driven flush marker. Events that arrive while the output beat cannot be replaced are dropped and counted.

## Interface
Parameters:
- C_DATA_WIDTH, 32, AXIS tdata width; beat = {id, timestamp}
- C_ID_WIDTH, 8, event ID width; timestamp width = C_DATA_WIDTH - C_ID_WIDTH
- C_PKT_LEN, 4, beats per full packet (>= 2)
- C_FLUSH_TIMEOUT, 64, idle cycles mid-packet before flush (>= 1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = capture events; 0 = ignore event_valid (not counted as drops)
- event_valid  in  1  one-cycle event strobe
- event_id  in  C_ID_WIDTH  event identifier; all-ones value reserved for flush marker
- out_tdata  out  C_DATA_WIDTH  {id, timestamp}
- out_tvalid  out  1  beat valid
- out_tready  in  1  downstream ready (FIFO not full)
- out_tlast  out  1  last beat of packet
- dropped_count  out  16  saturating count of dropped events

## Operation
- Timestamp counter ts, C_DATA_WIDTH-C_ID_WIDTH bits, free-running, +1 every cycle, wraps to 0; value 0 in first cycle after reset.
- One output beat register. The register can load ("slot free") when out_tvalid=0, or when out_tvalid && out_tready in the same cycle.
- Event: enable && event_valid.
  - If slot free: load {event_id, ts sampled this cycle}.
  - Otherwise: drop; dropped_count += 1, saturating at 0xFFFF.
- Beat counter bcnt, 0..C_PKT_LEN-1, increments on every load.
  - out_tlast = 1 on the load where bcnt == C_PKT_LEN-1; bcnt then returns to 0.
- States:
  - IDLE (bcnt == 0): no timeout counting.
  - PKT (bcnt != 0): idle counter tcnt increments on each cycle with no event; clears on any event, accepted or dropped.
  - FLUSH: entered when tcnt reaches C_FLUSH_TIMEOUT. Loads marker {all-ones, ts} with tlast=1 at the first cycle the slot is free, then goes to IDLE with bcnt=0 and tcnt=0.
- Simultaneous event and timeout expiry in the same cycle: the event wins, tcnt clears, no flush.
- Event while in FLUSH with slot not free: dropped and counted; remains in FLUSH.
- Event while in FLUSH with slot free: the event is loaded and ends the packet. tlast=1 on it, bcnt returns to 0, no marker is sent. The packet is then at most C_PKT_LEN beats.
- enable=0 does not stop ts, tcnt, or a pending flush.
- A user event_id equal to all-ones is transmitted unchanged. Its use by software is prohibited.

## Timing
- Reset values: out_tvalid=0, out_tlast=0, out_tdata=0, dropped_count=0, bcnt=0, tcnt=0, ts=0, state IDLE.
- Latency: event accepted in cycle N gives out_tvalid=1 in cycle N+1, carrying ts(N).
- AXIS rules:
  - out_tdata and out_tlast stay stable while out_tvalid && !out_tready.
  - out_tvalid deasserts only after a handshake with no new load.
- Throughput: one beat per cycle with out_tready held high.
- Flush: marker appears C_FLUSH_TIMEOUT+1 cycles after the last mid-packet event, if the slot is free.
- Reset mid-packet: out_tvalid drops in the cycle after reset is sampled. The truncated packet carries no tlast; downstream tolerates this.

## Test plan
- Back-to-back beats: out_tready=1; events with IDs 1,2,3,4 in consecutive cycles starting at ts=10 -> four beats {1,10},{2,11},{3,12},{4,13}, out_tlast only on the 4th; dropped_count=0.
- Backpressure: out_tready=0; events with IDs 5,6,7 in consecutive cycles -> {5,ts0} held stable, dropped_count=2; release out_tready -> one beat, then out_tvalid=0.
- Timeout flush: 2 events, then idle with out_tready=1 -> after 64 idle cycles a beat with id=0xFF and tlast=1; the next event starts a new packet with bcnt=0.
- Timeout collision: event exactly on the expiry cycle -> no marker, event loaded as beat 3; the packet ends on the following event with tlast.
- Disabled capture: enable=0 with event_valid pulses -> no beats, dropped_count unchanged, ts still advancing.
- Reset mid-packet, then saturation:
  - Reset after beat 2 -> all outputs return to reset values in the next cycle.
  - Then hold out_tready=0 and apply 70000 events -> dropped_count=0xFFFF.
